// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (cpu/dma) arbiter in front of a single-port DMEM.
// Define DMEM_ARB_RR_EN for round-robin; default is fixed CPU priority.
module dmem_arbiter #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDRESS_SIZE-1:0] cpu_addr,
  input  logic [DATA_SIZE-1:0]    cpu_wdata,
  input  logic [1:0]              cpu_wsize,
  input  logic [2:0]              cpu_rsize,
  output logic                    cpu_gnt,
  output logic                    cpu_rvalid,
  output logic [DATA_SIZE-1:0]    cpu_rdata,
  input  logic                    dma_req,
  input  logic                    dma_we,
  input  logic [ADDRESS_SIZE-1:0] dma_addr,
  input  logic [DATA_SIZE-1:0]    dma_wdata,
  input  logic [1:0]              dma_wsize,
  input  logic [2:0]              dma_rsize,
  output logic                    dma_gnt,
  output logic                    dma_rvalid,
  output logic [DATA_SIZE-1:0]    dma_rdata,
  output logic                    mem_rw,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [1:0]              mem_datain,
  output logic [2:0]              mem_dataout,
  output logic [DATA_SIZE-1:0]    mem_dataw,
  input  logic [DATA_SIZE-1:0]    mem_datar
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic [1:0]              wsize_q, wsize_d;
  logic [2:0]              rsize_q, rsize_d;
  logic                    owner_q, owner_d;
  logic [DATA_SIZE-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DATA_SIZE-1:0]    dma_rdata_q, dma_rdata_d;
  logic                    cpu_rvalid_q, cpu_rvalid_d;
  logic                    dma_rvalid_q, dma_rvalid_d;
  logic                    dma_first;
  logic                    idle;

  assign idle = (state_q == IDLE);

`ifdef DMEM_ARB_RR_EN
  // ptr_q=1 means DMA wins the next tie
  logic ptr_q, ptr_d;

  assign dma_first = ptr_q;

  // pointer moves to the port that was not just granted
  always_comb begin
    ptr_d = ptr_q;
    if (cpu_gnt)
      ptr_d = 1'b1;
    else if (dma_gnt)
      ptr_d = 1'b0;
  end

  // pointer register, CPU first out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= 1'b0;
    else
      ptr_q <= ptr_d;
  end
`else
  assign dma_first = 1'b0;
`endif

  // grant is combinational and only possible in IDLE
  always_comb begin
    cpu_gnt = idle & cpu_req & (~dma_req | ~dma_first);
    dma_gnt = idle & dma_req & (~cpu_req | dma_first);
  end

  // next-state: latch winner in IDLE, return load data after ACCESS
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wsize_d      = wsize_q;
    rsize_d      = rsize_q;
    owner_d      = owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          dma_gnt: begin
            state_d = ACCESS;
            owner_d = 1'b1;
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
            wsize_d = dma_wsize;
            rsize_d = dma_rsize;
          end
          cpu_gnt: begin
            state_d = ACCESS;
            owner_d = 1'b0;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            wsize_d = cpu_wsize;
            rsize_d = cpu_rsize;
          end
          default: ;
        endcase
      end
      ACCESS: begin
        state_d = IDLE;
        if (!we_q) begin
          if (owner_q) begin
            dma_rvalid_d = 1'b1;
            dma_rdata_d  = mem_datar;
          end else begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = mem_datar;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wsize_q      <= 2'b00;
      rsize_q      <= 3'b000;
      owner_q      <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wsize_q      <= wsize_d;
      rsize_q      <= rsize_d;
      owner_q      <= owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  // write strobe only while ACCESS; reset drops it at once
  assign mem_rw      = (state_q == ACCESS) & we_q;
  assign mem_addr    = addr_q;
  assign mem_datain  = wsize_q;
  assign mem_dataout = rsize_q;
  assign mem_dataw   = wdata_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign dma_rvalid  = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a behavioural DMEM and
// per-port expected-load-data queues.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_wsize;
  logic [2:0]  cpu_rsize;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [1:0]  dma_wsize;
  logic [2:0]  dma_rsize;
  logic        mem_rw;
  logic [31:0] mem_addr, mem_dataw, mem_datar;
  logic [1:0]  mem_datain;
  logic [2:0]  mem_dataout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qc[$];
  logic [31:0] qd[$];
  logic [31:0] dmem [0:255];

  dmem_arbiter #(.DATA_SIZE(32), .ADDRESS_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wsize(cpu_wsize), .cpu_rsize(cpu_rsize),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wsize(dma_wsize), .dma_rsize(dma_rsize),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .mem_dataw(mem_dataw),
    .mem_datar(mem_datar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld(input logic [31:0] w,
                                     input logic [2:0] c);
    case (c)
      3'b000:  ld = w;
      3'b001:  ld = {{24{w[7]}}, w[7:0]};
      3'b010:  ld = {{16{w[15]}}, w[15:0]};
      3'b101:  ld = {24'h0, w[7:0]};
      3'b110:  ld = {16'h0, w[15:0]};
      default: ld = w;
    endcase
  endfunction

  always_comb mem_datar = ld(dmem[mem_addr[7:0]], mem_dataout);

  always @(negedge clk) begin
    if (mem_rw) begin
      case (mem_datain)
        2'b00: dmem[mem_addr[7:0]] <= mem_dataw;
        2'b01: dmem[mem_addr[7:0]][7:0] <= mem_dataw[7:0];
        2'b10: dmem[mem_addr[7:0]][15:0] <= mem_dataw[15:0];
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (qc.size() == 0) chk("cpu_rvalid_spurious", 1, 0);
      else chk("cpu_rdata", cpu_rdata, qc.pop_front());
    end
    if (dma_rvalid) begin
      if (qd.size() == 0) chk("dma_rvalid_spurious", 1, 0);
      else chk("dma_rdata", dma_rdata, qd.pop_front());
    end
  end

  task automatic drive(input bit port, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] ws, input logic [2:0] rs);
    if (port) begin
      dma_req = req; dma_we = we; dma_addr = a;
      dma_wdata = wd; dma_wsize = ws; dma_rsize = rs;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a;
      cpu_wdata = wd; cpu_wsize = ws; cpu_rsize = rs;
    end
  endtask

  // one transaction: grant cycle then ACCESS cycle; returns in N+2
  task automatic xact(input bit port, input logic we,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] ws, input logic [2:0] rs,
                      input logic [31:0] exp);
    drive(port, 1'b1, we, a, wd, ws, rs);
    if (!we) begin
      if (port) qd.push_back(exp);
      else qc.push_back(exp);
    end
    @(negedge clk);
    chk("gnt_cpu", cpu_gnt, !port);
    chk("gnt_dma", dma_gnt, port);
    chk("idle_rw", mem_rw, 0);
    @(posedge clk); #1;
    drive(port, 1'b0, ~we, ~a, ~wd, ~ws, ~rs);
    @(negedge clk);
    chk("acc_gnt", {cpu_gnt, dma_gnt}, 0);
    chk("acc_rw", mem_rw, we);
    chk("acc_addr", mem_addr, a);
    chk("acc_ws", mem_datain, ws);
    chk("acc_rs", mem_dataout, rs);
    chk("acc_wd", mem_dataw, wd);
    @(posedge clk); #1;
  endtask

  initial begin
    bit exp_dma;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[32'h20] = 32'h11223344;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_gnt", {cpu_gnt, dma_gnt}, 0);
    chk("rst_rw", mem_rw, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_sizes", {mem_datain, mem_dataout}, 0);
    chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // store then load, back to back: gnt cycles 0,2 and rvalid cycle 4
    xact(0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 3'b000, 0);
    xact(0, 0, 32'h10, 32'h0, 2'b00, 3'b000, 32'hDEADBEEF);
    @(negedge clk);
    chk("c4_rvalid", cpu_rvalid, 1);
    chk("c4_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("c4_dma_rvalid", dma_rvalid, 0);
    @(posedge clk); #1;

    // byte store, signed and unsigned byte loads
    xact(0, 1, 32'h30, 32'h00000080, 2'b01, 3'b000, 0);
    xact(0, 0, 32'h30, 32'h0, 2'b00, 3'b001, 32'hFFFFFF80);
    xact(0, 0, 32'h30, 32'h0, 2'b00, 3'b101, 32'h00000080);

    // unsupported rsize still returns data
    xact(1, 0, 32'h10, 32'h0, 2'b00, 3'b011, 32'hDEADBEEF);

    // half store and loads from both ports
    xact(1, 1, 32'h40, 32'h1234ABCD, 2'b10, 3'b000, 0);
    xact(1, 0, 32'h40, 32'h0, 2'b00, 3'b110, 32'h0000ABCD);
    xact(0, 0, 32'h40, 32'h0, 2'b00, 3'b010, 32'hFFFFABCD);
    repeat (3) @(posedge clk); #1;
    chk("cpu_hold", cpu_rdata, 32'hFFFFABCD);
    chk("dma_hold", dma_rdata, 32'h0000ABCD);

    // request arriving during ACCESS waits for the next IDLE cycle
    drive(0, 1, 1, 32'h50, 32'hA5A5A5A5, 2'b00, 3'b000);
    @(negedge clk);
    chk("r22_cgnt", cpu_gnt, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h50, 0, 2'b00, 3'b000);
    qd.push_back(32'hA5A5A5A5);
    @(negedge clk);
    chk("r22_acc_gnt", {cpu_gnt, dma_gnt}, 0);
    chk("r22_acc_rw", mem_rw, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r22_dgnt", dma_gnt, 1);
    chk("r22_idle_rw", mem_rw, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r22_rvalid", dma_rvalid, 1);
    @(posedge clk); #1;

    // reset in the middle of a DMA store aborts it
    drive(1, 1, 1, 32'h20, 32'hCAFEF00D, 2'b00, 3'b000);
    @(negedge clk);
    chk("ab_gnt", dma_gnt, 1);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ab_rw_pre", mem_rw, 1);
    rst_n = 1'b0;
    #1;
    chk("ab_rw", mem_rw, 0);
    chk("ab_addr", mem_addr, 0);
    chk("ab_wd", mem_dataw, 0);
    chk("ab_sizes", {mem_datain, mem_dataout}, 0);
    chk("ab_rdata", cpu_rdata | dma_rdata, 0);
    @(negedge clk); #1;
    chk("ab_mem", dmem[32'h20], 32'h11223344);
    chk("ab_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    xact(1, 0, 32'h20, 32'h0, 2'b00, 3'b000, 32'h11223344);
    @(negedge clk);
    chk("ab_ld_rvalid", dma_rvalid, 1);
    @(posedge clk); #1;

    // both requests held: alternate (RR) or CPU always (fixed)
    exp_dma = 1'b0;
    drive(0, 1, 0, 32'h10, 0, 2'b00, 3'b000);
    drive(1, 1, 0, 32'h30, 0, 2'b00, 3'b101);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("arb_cgnt", cpu_gnt, !exp_dma);
        chk("arb_dgnt", dma_gnt, exp_dma);
        if (exp_dma) qd.push_back(32'h00000080);
        else qc.push_back(32'hDEADBEEF);
`ifdef DMEM_ARB_RR_EN
        exp_dma = !exp_dma;
`endif
      end else begin
        chk("arb_acc_gnt", {cpu_gnt, dma_gnt}, 0);
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk); #1;

    chk("qc_empty", qc.size(), 0);
    chk("qd_empty", qd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
